enc_match_ctrl: RTL
===================

Name: enc_match_ctrl

Overview:
- Sequencing controller for the encode/store/compare datapath.
- Enrolls a reference code: the 4-bit log2 bucket of a 10-bit input.
- Services verify requests against the enrolled code and reports match/mismatch through a req/ack handshake.
- Counts consecutive mismatches and locks out after MAX_FAIL; the lockout is the countermeasure against brute-force probing of the stored code.

Parameters:
- MAX_FAIL, 3: consecutive failed verifies that force LOCK (range 1..(2**CNT_W)-1).
- CNT_W, 3: width of fail_cnt.

Ports:
- c  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- i  input  10  data word to be encoded; sampled on the accept edge only.
- enroll_req  input  1  request to store code(i) as reference.
- verify_req  input  1  request to compare code(i) with reference.
- busy  output  1  controller not in IDLE and not in LOCK.
- ack  output  1  one-cycle completion pulse.
- match  output  1  verify result; valid only while ack=1, else 0.
- locked  output  1  controller in LOCK.
- ref_valid  output  1  a reference has been enrolled.
- fail_cnt  output  CNT_W  consecutive failed verifies.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, ack, match, locked, ref_valid, fail_cnt = 0.
  - ref_code = 0, probe_code = 0.
  - Reset asserted mid-operation aborts immediately; no ack is issued for the aborted request.
- Encoding code(i), 4 bits:
  - i==0 -> 0; 1..3 -> 1.
  - Otherwise, for 4 <= i <= 1023: index of the most significant 1 (4..7 -> 2, 8..15 -> 3, …, 512..1023 -> 9).
  - Values 10..15 never occur.
- States: IDLE, COMPARE, RESP, LOCK. All outputs are registered.
- IDLE, edge k:
  - enroll_req=1: ref_code<=code(i), ref_valid<=1, fail_cnt<=0, next=RESP with match=0.
  - Else verify_req=1: probe_code<=code(i), next=COMPARE.
  - Both high in the same cycle: enroll wins; verify is dropped.
  - Neither high: stay in IDLE.
- COMPARE, edge k+1:
  - hit = ref_valid & (probe_code==ref_code).
  - hit: fail_cnt<=0.
  - No hit and ref_valid=1: fail_cnt<=fail_cnt+1, saturating at 2**CNT_W-1.
  - ref_valid=0: result is mismatch, fail_cnt unchanged (no enrolled reference is not an attack attempt).
  - match register <= hit; next=RESP.
- RESP (one cycle): ack=1, match valid.
  - Next edge: state goes to LOCK if fail_cnt>=MAX_FAIL, else IDLE; match is cleared.
- Latency:
  - verify: ack high in the cycle after edge k+1 (2 cycles after the accept edge).
  - enroll: ack high in the cycle after edge k (1 cycle).
- Requests are level-sampled only in IDLE; requests asserted in COMPARE/RESP are ignored, not queued.
  - A request still held high on return to IDLE is a new request.
  - Requesters must deassert on ack.
- LOCK:
  - locked=1, busy=0.
  - All requests ignored; no ack ever issued.
  - Exit only via rst_n.
  - ref_code and fail_cnt held for readout.
- i is don't-care except at the accept edge.

Decomposition:
- Shared package:
  - state enum (IDLE, COMPARE, RESP, LOCK).
  - CODE_W=4.
  - DATA_W=10.
- One sub-module: log2_bucket, combinational, 10-bit in / 4-bit out, implementing code(i) above. It is reusable by the datapath owners.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst_n=0 mid-verify (state=COMPARE).
  - Response: all outputs 0 immediately, no ack afterwards, ref_valid=0.
- Enroll then matching verify:
  - Stimulus: enroll i=100 (code 6), then verify i=127.
  - Response: ack with match=1, fail_cnt=0; ack 2 cycles after accept.
- Encoder boundaries:
  - Stimulus: enroll 0, 3, 4, 511, 512, 1023, each followed by verify of the same i.
  - Response: all match.
  - Stimulus: enroll 3, verify 4.
  - Response: match=0.
- Lockout with MAX_FAIL=3:
  - Stimulus: enroll 8; verify 1, 2, 1023.
  - Response: fail_cnt 1, 2, 3, three acks with match=0, then locked=1.
  - Stimulus: further enroll/verify requests.
  - Response: no ack, busy=0.
- Fail counter cleared and no-reference verify:
  - Stimulus: two failed verifies, then a matching verify.
  - Response: fail_cnt 2 -> 0.
  - Stimulus: after a fresh reset, verify i=5.
  - Response: ack, match=0, fail_cnt stays 0.
- Simultaneous and ignored requests:
  - Stimulus: enroll_req=verify_req=1 in IDLE with i=40.
  - Response: enroll only (ref code 5), one ack, match=0.
  - Stimulus: pulse verify_req during COMPARE.
  - Response: ignored, exactly one ack.

Source files
------------

// File: rtl/enc_match_ctrl_pkg.sv
// Shared types and widths for the encode/store/compare controller and its encoder.
package enc_match_ctrl_pkg;

  localparam int CODE_W = 4;
  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESP    = 2'd2,
    LOCK    = 2'd3
  } state_t;

endpackage

// File: rtl/enc_match_ctrl_log2_bucket.sv
// Combinational log2 bucket encoder: 0 -> 0, 1..3 -> 1, otherwise index of the top set bit.
module log2_bucket
  import enc_match_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] i,
  output logic [CODE_W-1:0] code
);

  // Ascending scan so the highest set bit at or above bit 2 wins; bits 1..0 fold into bucket 1.
  always_comb begin
    code = '0;
    if (i[1] | i[0]) begin
      code = CODE_W'(1);
    end
    for (int b = 2; b < DATA_W; b++) begin
      if (i[b]) begin
        code = CODE_W'(b);
      end
    end
  end

endmodule

// File: rtl/enc_match_ctrl.sv
// Enroll/verify sequencing controller with consecutive-mismatch lockout.
module enc_match_ctrl
  import enc_match_ctrl_pkg::*;
#(
  parameter int MAX_FAIL = 3,
  parameter int CNT_W    = 3
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i,
  input  logic              enroll_req,
  input  logic              verify_req,
  output logic              busy,
  output logic              ack,
  output logic              match,
  output logic              locked,
  output logic              ref_valid,
  output logic [CNT_W-1:0]  fail_cnt
);

  localparam logic [CNT_W-1:0] FAIL_LIMIT = CNT_W'(MAX_FAIL);
  localparam logic [CNT_W-1:0] FAIL_SAT   = '1;

  state_t              state, state_d;
  logic [CODE_W-1:0]   ref_code, ref_code_d;
  logic [CODE_W-1:0]   probe_code, probe_code_d;
  logic [CODE_W-1:0]   code_i;
  logic                ref_valid_d;
  logic [CNT_W-1:0]    fail_cnt_d;
  logic                match_d;
  logic                hit;

  log2_bucket u_log2_bucket (
    .i    (i),
    .code (code_i)
  );

  assign hit = ref_valid & (probe_code == ref_code);

  // Outputs are flopped from the next-state decode so they change only on clock edges.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ref_code   <= '0;
      probe_code <= '0;
      ref_valid  <= 1'b0;
      fail_cnt   <= '0;
      match      <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_d;
      ref_code   <= ref_code_d;
      probe_code <= probe_code_d;
      ref_valid  <= ref_valid_d;
      fail_cnt   <= fail_cnt_d;
      match      <= match_d;
      ack        <= (state_d == RESP);
      busy       <= (state_d == COMPARE) || (state_d == RESP);
      locked     <= (state_d == LOCK);
    end
  end

  always_comb begin
    state_d      = state;
    ref_code_d   = ref_code;
    probe_code_d = probe_code;
    ref_valid_d  = ref_valid;
    fail_cnt_d   = fail_cnt;
    match_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enroll_req) begin
          ref_code_d  = code_i;
          ref_valid_d = 1'b1;
          fail_cnt_d  = '0;
          state_d     = RESP;
        end else if (verify_req) begin
          probe_code_d = code_i;
          state_d      = COMPARE;
        end
      end
      COMPARE: begin
        // A verify with nothing enrolled is a plain mismatch, not a probing attempt.
        match_d = hit;
        if (hit) begin
          fail_cnt_d = '0;
        end else if (ref_valid && (fail_cnt != FAIL_SAT)) begin
          fail_cnt_d = fail_cnt + CNT_W'(1);
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = (fail_cnt >= FAIL_LIMIT) ? LOCK : IDLE;
      end
      LOCK: begin
        state_d = LOCK;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
